// File: rtl/srfp_pkg.sv
// Single-precision field layout, special encodings and the operand unpack helper,
// shared by the multiplier and the same-sign adder of the butterfly datapath.
package srfp_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_HI   = 30;
   localparam int EXP_LO   = 23;
   localparam int MAN_HI   = 22;
   localparam int MAN_LO   = 0;
   localparam int BIAS     = 127;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_NAN  = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] man;      // hidden one included
      logic        is_zero;
      logic        is_nan;
   } fp_unp_t;

   // Exponent 0 covers denormals as well, which flush to zero.
   function automatic fp_unp_t fp_unpack(input logic [31:0] x);
      fp_unp_t u;
      u.sign    = x[SIGN_BIT];
      u.exp     = x[EXP_HI:EXP_LO];
      u.man     = {1'b1, x[MAN_HI:MAN_LO]};
      u.is_zero = (u.exp == 8'd0);
      u.is_nan  = (u.exp == 8'hFF);
      return u;
   endfunction

endpackage

// File: rtl/srmul_norm.sv
// Normalize, truncate and pack a raw 48-bit mantissa product, clamping
// underflow to zero and overflow / special inputs to the all-ones NaN.
module srmul_norm
   import srfp_pkg::*;
(
   input  logic [47:0]       p_i,
   input  logic signed [9:0] e_i,
   input  logic              zs_i,
   input  logic              is_zero_i,
   input  logic              is_nan_i,
   output logic [31:0]       z_o
);

   logic signed [9:0] ze;
   logic [22:0]       zm;
   logic              unused_lo;

   // Rounding truncates, so the low product bits never matter.
   assign unused_lo = ^p_i[22:0];

   always_comb begin
      ze = e_i;
      zm = p_i[45:23];
      if (p_i[47]) begin
         ze = e_i + 10'sd1;
         zm = p_i[46:24];
      end

      z_o = {zs_i, ze[7:0], zm};
      if (is_zero_i)
         z_o = FP_ZERO;
      else if (is_nan_i || ze >= 10'sd255)
         z_o = FP_NAN;
      else if (ze <= 10'sd0)
         z_o = FP_ZERO;
   end

endmodule

// File: rtl/srmul_pipe.sv
// Three-stage pipelined single-precision multiplier (unpack, multiply, normalize)
// with valid/ready on both sides and a tag carried alongside each operand pair.
module srmul_pipe
   import srfp_pkg::*;
#(
   parameter int TAGW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_z,
   output logic [TAGW-1:0] out_tag
);

   logic [3:1] v_q, v_d;
   logic       adv1, adv2, adv3;

   fp_unp_t         a1_q, b1_q, a1_d, b1_d;
   logic [TAGW-1:0] tag1_q, tag2_q, tag3_q;

   logic [47:0]       p2_q, p2_d;
   logic signed [9:0] e2_q, e2_d;
   logic              zs2_q, zs2_d, zero2_q, zero2_d, nan2_q, nan2_d;

   logic [31:0] z3_q, z3_d;

   // A stage may take new data when it is empty or its contents move on, so
   // bubbles collapse even while the output is stalled.
   assign adv3     = out_ready | ~v_q[3];
   assign adv2     = adv3 | ~v_q[2];
   assign adv1     = adv2 | ~v_q[1];
   assign in_ready = adv1 & ~rst;

   assign out_valid = v_q[3];
   assign out_z     = z3_q;
   assign out_tag   = tag3_q;

   always_comb begin
      v_d = v_q;
      if (adv3) v_d[3] = v_q[2];
      if (adv2) v_d[2] = v_q[1];
      if (adv1) v_d[1] = in_valid;
   end

   always_comb begin
      a1_d = fp_unpack(in_a);
      b1_d = fp_unpack(in_b);
   end

   // Zero wins over NaN, so 0 * inf yields 0.
   always_comb begin
      zs2_d   = a1_q.sign ^ b1_q.sign;
      zero2_d = a1_q.is_zero | b1_q.is_zero;
      nan2_d  = (a1_q.is_nan | b1_q.is_nan) & ~zero2_d;
      p2_d    = 48'(a1_q.man) * 48'(b1_q.man);
      e2_d    = $signed({2'b00, a1_q.exp} + {2'b00, b1_q.exp} - 10'(BIAS));
   end

   srmul_norm u_norm (
      .p_i       (p2_q),
      .e_i       (e2_q),
      .zs_i      (zs2_q),
      .is_zero_i (zero2_q),
      .is_nan_i  (nan2_q),
      .z_o       (z3_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= '0;
         z3_q   <= FP_ZERO;
         tag3_q <= '0;
      end else begin
         v_q <= v_d;
         if (adv3 && v_q[2]) begin
            z3_q   <= z3_d;
            tag3_q <= tag2_q;
         end
      end
   end

   // Payload registers only load alongside a valid bit; their stale contents
   // are never observed because the valid bits gate everything downstream.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         tag1_q <= in_tag;
      end
      if (adv2 && v_q[1]) begin
         p2_q    <= p2_d;
         e2_q    <= e2_d;
         zs2_q   <= zs2_d;
         zero2_q <= zero2_d;
         nan2_q  <= nan2_d;
         tag2_q  <= tag1_q;
      end
   end

endmodule
